// File: rtl/monitor_sched_pkg.sv
// rtl/monitor_sched_pkg.sv - shared types and constants for the monitor evaluation scheduler
package monitor_sched_pkg;

    localparam int SCHED_TS_W       = 64;
    localparam int SCHED_NUM_INPUTS = 1;

    typedef enum logic {
        IDLE = 1'b0,
        EVAL = 1'b1
    } sched_state_t;

    // Event record in the default configuration; the top builds its own
    // record type when NUM_INPUTS / TS_W are overridden.
    typedef struct packed {
        logic [SCHED_NUM_INPUTS-1:0] mask;
        logic                        periodic;
        logic [SCHED_TS_W-1:0]       ts;
    } ev_rec_t;

    // Width of a layer index; never narrower than one bit.
    function automatic int layer_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int SCHED_LAYER_W = layer_idx_w(3);

endpackage

// File: rtl/sched_event_fifo.sv
// rtl/sched_event_fifo.sv - event record queue with simultaneous push and pop
// Ports:
//   clk, rst (async active-low), en (freezes all state when low)
//   push/wdata  - offer a record; accept reports whether it was stored
//   pop/rdata   - consume the head record (ignored when empty)
//   empty, full, count - occupancy
module sched_event_fifo
    import monitor_sched_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type rec_t = ev_rec_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     push,
    input  rec_t                     wdata,
    output logic                     accept,
    input  logic                     pop,
    output rec_t                     rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = DEPTH[AW:0];

    rec_t          r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;
    logic          w_pop;
    logic          w_push;

    assign empty = (r_cnt == '0);
    assign full  = (r_cnt == FULL_CNT);
    assign count = r_cnt;
    assign rdata = r_mem[r_rd];

    // A full queue still takes a record when the head leaves in the same cycle.
    assign w_pop  = en & pop & ~empty;
    assign w_push = en & push & (~full | w_pop);
    assign accept = w_push;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= wdata;
    end

endmodule

// File: rtl/monitor_eval_scheduler.sv
// rtl/monitor_eval_scheduler.sv - sequences one RTLola monitor evaluation pipeline
// Optional feature macro: MONITOR_SCHED_DT_EN (ev_dt = distance to previous evaluated event).
// Ports:
//   clk, rst (async active-low), en (global enable, low freezes everything)
//   new_input                       - per-stream arrival strobes
//   q_push, q_push_valid            - event generated / accepted into the queue
//   q_pop, q_pop_valid              - scheduler request / head returned
//   ev_mask, ev_periodic, ev_ts     - event under evaluation
//   ev_dt                           - timestamp delta (zero unless feature enabled)
//   enable_in, layer_en, slide      - datapath strobes
//   busy, overflow                  - status
module monitor_eval_scheduler
    import monitor_sched_pkg::*;
#(
    parameter int NUM_INPUTS  = SCHED_NUM_INPUTS,
    parameter int NUM_LAYERS  = 3,
    parameter int PERIOD      = 1000,
    parameter int QUEUE_DEPTH = 4,
    parameter int TS_W        = SCHED_TS_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [NUM_INPUTS-1:0] new_input,
    output logic                  q_push,
    output logic                  q_push_valid,
    output logic                  q_pop,
    output logic                  q_pop_valid,
    output logic [NUM_INPUTS-1:0] ev_mask,
    output logic                  ev_periodic,
    output logic [TS_W-1:0]       ev_ts,
    output logic [TS_W-1:0]       ev_dt,
    output logic                  enable_in,
    output logic [NUM_LAYERS-1:0] layer_en,
    output logic                  slide,
    output logic                  busy,
    output logic                  overflow
);

    localparam int              PC_W       = $clog2(PERIOD);
    localparam int              LW         = layer_idx_w(NUM_LAYERS);
    localparam logic [PC_W-1:0] PC_LAST    = PC_W'(PERIOD - 1);
    localparam logic [LW-1:0]   LAYER_LAST = LW'(NUM_LAYERS - 1);

    typedef struct packed {
        logic [NUM_INPUTS-1:0] mask;
        logic                  periodic;
        logic [TS_W-1:0]       ts;
    } rec_t;

    logic [TS_W-1:0]            r_ts;
    logic [PC_W-1:0]            r_pcnt;
    sched_state_t               r_state;
    logic [LW-1:0]              r_layer;
    rec_t                       r_ev;
    logic                       r_overflow;

    logic                       w_en;
    logic                       w_deadline;
    logic                       w_push;
    logic                       w_pop_req;
    logic                       w_pop_valid;
    logic                       w_accept;
    logic                       w_empty;
    logic                       w_full;
    logic [$clog2(QUEUE_DEPTH):0] w_count;
    rec_t                       w_rec;
    rec_t                       w_head;
    logic                       w_eval_act;
    logic                       w_layer0;

    // Reset is immediate, so strobes are masked by it as well as by en.
    assign w_en        = en & rst;
    assign w_deadline  = (r_pcnt == PC_LAST);
    assign w_push      = w_en & ((|new_input) | w_deadline);
    assign w_pop_req   = w_en & (r_state == IDLE);
    assign w_pop_valid = w_pop_req & ~w_empty;
    assign w_rec       = {new_input, w_deadline, r_ts};

    sched_event_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .rec_t (rec_t)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .en     (w_en),
        .push   (w_push),
        .wdata  (w_rec),
        .accept (w_accept),
        .pop    (w_pop_req),
        .rdata  (w_head),
        .empty  (w_empty),
        .full   (w_full),
        .count  (w_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ts       <= '0;
            r_pcnt     <= '0;
            r_state    <= IDLE;
            r_layer    <= '0;
            r_ev       <= '0;
            r_overflow <= 1'b0;
        end else if (en) begin
            r_ts   <= r_ts + 1'b1;
            r_pcnt <= w_deadline ? '0 : r_pcnt + 1'b1;
            if (w_push & w_full & ~w_pop_valid) r_overflow <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_pop_valid) begin
                        r_ev    <= w_head;
                        r_layer <= '0;
                        r_state <= EVAL;
                    end
                end
                EVAL: begin
                    if (r_layer == LAYER_LAST) r_state <= IDLE;
                    else                       r_layer <= r_layer + 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef MONITOR_SCHED_DT_EN
    logic [TS_W-1:0] r_prev_ts;
    logic [TS_W-1:0] r_ev_dt;

    // Previous timestamp starts at zero so the first event reports its own ts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev_ts <= '0;
            r_ev_dt   <= '0;
        end else if (w_pop_valid) begin
            r_ev_dt   <= w_head.ts - r_prev_ts;
            r_prev_ts <= w_head.ts;
        end
    end

    assign ev_dt = r_ev_dt;
`else
    assign ev_dt = '0;
`endif

    assign w_eval_act = w_en & (r_state == EVAL);
    assign w_layer0   = w_eval_act & (r_layer == '0);

    assign q_push       = w_push;
    assign q_push_valid = w_accept;
    assign q_pop        = w_pop_req;
    assign q_pop_valid  = w_pop_valid;
    assign ev_mask      = r_ev.mask;
    assign ev_periodic  = r_ev.periodic;
    assign ev_ts        = r_ev.ts;
    assign layer_en     = w_eval_act ? (NUM_LAYERS'(1) << r_layer) : '0;
    assign enable_in    = w_layer0 & (|r_ev.mask);
    assign slide        = w_layer0 & r_ev.periodic;
    assign busy         = (r_state == EVAL) | (w_count != '0);
    assign overflow     = r_overflow;

endmodule
